id_ex_ctl_stage: RTL and testbench

ID_EX_CTL_STAGE -- requirements
Module: id_ex_ctl_stage

---
 rtl/id_ex_ctl_stage.sv | 156 +++++++++++++++
 tb/tb_id_ex_ctl_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_ctl_stage.sv
// rtl/id_ex_ctl_stage.sv - ID/EX control pipeline register with load-use bubble insertion
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_ctl_stage #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [1:0]            i_result_src,
  input  logic                  i_branch,
  input  logic                  i_jmp,
  input  logic                  i_mem_write,
  input  logic                  i_reg_write,
  input  logic [2:0]            i_alu_ctl,
  input  logic                  i_alu_src_opb,
  input  logic [1:0]            i_alu_src_opa,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_stall,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [1:0]            o_result_src,
  output logic                  o_branch,
  output logic                  o_jmp,
  output logic                  o_mem_write,
  output logic                  o_reg_write,
  output logic [2:0]            o_alu_ctl,
  output logic                  o_alu_src_opb,
  output logic [1:0]            o_alu_src_opa,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  o_load_use,
  output logic [CNT_W-1:0]      o_bubble_cnt
);

  logic                  valid_q, valid_d;
  logic [1:0]            result_src_q, result_src_d;
  logic                  branch_q, branch_d;
  logic                  jmp_q, jmp_d;
  logic                  mem_write_q, mem_write_d;
  logic                  reg_write_q, reg_write_d;
  logic [2:0]            alu_ctl_q, alu_ctl_d;
  logic                  alu_src_opb_q, alu_src_opb_d;
  logic [1:0]            alu_src_opa_q, alu_src_opa_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;

  logic held_load;
  logic load_use;
  logic bubble;

  // Registers clear asynchronously, so the hazard flag is 0 during reset too.
  assign held_load = valid_q && reg_write_q && (result_src_q == 2'b01);
  assign load_use  = held_load && (rd_q != '0) && i_valid &&
                     ((rd_q == i_rs1) || (rd_q == i_rs2));
  assign bubble    = i_flush || (!i_stall && load_use);

  always_comb begin
    valid_d       = valid_q;
    result_src_d  = result_src_q;
    branch_d      = branch_q;
    jmp_d         = jmp_q;
    mem_write_d   = mem_write_q;
    reg_write_d   = reg_write_q;
    alu_ctl_d     = alu_ctl_q;
    alu_src_opb_d = alu_src_opb_q;
    alu_src_opa_d = alu_src_opa_q;
    rd_d          = rd_q;
    if (bubble) begin
      valid_d       = 1'b0;
      result_src_d  = '0;
      branch_d      = 1'b0;
      jmp_d         = 1'b0;
      mem_write_d   = 1'b0;
      reg_write_d   = 1'b0;
      alu_ctl_d     = '0;
      alu_src_opb_d = 1'b0;
      alu_src_opa_d = '0;
      rd_d          = '0;
    end else if (!i_stall) begin
      // Invalid slots pass through but are stripped of architectural side effects.
      valid_d       = i_valid;
      result_src_d  = i_result_src;
      branch_d      = i_valid && i_branch;
      jmp_d         = i_valid && i_jmp;
      mem_write_d   = i_valid && i_mem_write;
      reg_write_d   = i_valid && i_reg_write;
      alu_ctl_d     = i_alu_ctl;
      alu_src_opb_d = i_alu_src_opb;
      alu_src_opa_d = i_alu_src_opa;
      rd_d          = i_rd;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q       <= 1'b0;
      result_src_q  <= '0;
      branch_q      <= 1'b0;
      jmp_q         <= 1'b0;
      mem_write_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      alu_ctl_q     <= '0;
      alu_src_opb_q <= 1'b0;
      alu_src_opa_q <= '0;
      rd_q          <= '0;
    end else begin
      valid_q       <= valid_d;
      result_src_q  <= result_src_d;
      branch_q      <= branch_d;
      jmp_q         <= jmp_d;
      mem_write_q   <= mem_write_d;
      reg_write_q   <= reg_write_d;
      alu_ctl_q     <= alu_ctl_d;
      alu_src_opb_q <= alu_src_opb_d;
      alu_src_opa_q <= alu_src_opa_d;
      rd_q          <= rd_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_bubble_cnt = bubble_cnt_q;
`else
  assign o_bubble_cnt = '0;
`endif

  assign o_valid       = valid_q;
  assign o_result_src  = result_src_q;
  assign o_branch      = branch_q;
  assign o_jmp         = jmp_q;
  assign o_mem_write   = mem_write_q;
  assign o_reg_write   = reg_write_q;
  assign o_alu_ctl     = alu_ctl_q;
  assign o_alu_src_opb = alu_src_opb_q;
  assign o_alu_src_opa = alu_src_opa_q;
  assign o_rd          = rd_q;
  assign o_load_use    = load_use;

endmodule

// File: tb/tb_id_ex_ctl_stage.sv
// tb/tb_id_ex_ctl_stage.sv - directed self-checking bench for id_ex_ctl_stage
module tb_id_ex_ctl_stage;
  logic       i_clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       i_rst_n;
  logic       i_valid, i_branch, i_jmp, i_mem_write, i_reg_write, i_alu_src_opb;
  logic [1:0] i_result_src, i_alu_src_opa;
  logic [2:0] i_alu_ctl;
  logic [4:0] i_rs1, i_rs2, i_rd;
  logic       i_stall, i_flush;
  logic       o_valid, o_branch, o_jmp, o_mem_write, o_reg_write, o_alu_src_opb;
  logic [1:0] o_result_src, o_alu_src_opa;
  logic [2:0] o_alu_ctl;
  logic [4:0] o_rd;
  logic       o_load_use;
  logic [3:0] o_bubble_cnt;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  id_ex_ctl_stage #(.REG_ADDR_W(5), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_result_src(i_result_src),
    .i_branch(i_branch), .i_jmp(i_jmp), .i_mem_write(i_mem_write), .i_reg_write(i_reg_write),
    .i_alu_ctl(i_alu_ctl), .i_alu_src_opb(i_alu_src_opb), .i_alu_src_opa(i_alu_src_opa),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_stall(i_stall), .i_flush(i_flush),
    .o_valid(o_valid), .o_result_src(o_result_src), .o_branch(o_branch), .o_jmp(o_jmp),
    .o_mem_write(o_mem_write), .o_reg_write(o_reg_write), .o_alu_ctl(o_alu_ctl),
    .o_alu_src_opb(o_alu_src_opb), .o_alu_src_opa(o_alu_src_opa), .o_rd(o_rd),
    .o_load_use(o_load_use), .o_bubble_cnt(o_bubble_cnt)
  );

  always begin
    #5;
    if (clk_en) i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bump();
`ifdef ID_EX_BUBBLE_CNT_EN
    if (exp_cnt != 15) exp_cnt++;
`endif
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic nop();
    i_valid = 0; i_result_src = 0; i_branch = 0; i_jmp = 0; i_mem_write = 0;
    i_reg_write = 0; i_alu_ctl = 0; i_alu_src_opb = 0; i_alu_src_opa = 0;
    i_rs1 = 0; i_rs2 = 0; i_rd = 0; i_stall = 0; i_flush = 0;
  endtask

  task automatic drv_load(input logic [4:0] rd);
    nop();
    i_valid = 1; i_reg_write = 1; i_result_src = 2'b01; i_rd = rd;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, o_valid, 0);
    chk({tag, ".bundle"}, {o_result_src, o_branch, o_jmp, o_mem_write, o_reg_write,
                           o_alu_ctl, o_alu_src_opb, o_alu_src_opa}, 0);
    chk({tag, ".rd"}, o_rd, 0);
  endtask

  initial begin
    // Reset with every input high and no clock running
    i_rst_n = 0;
    i_valid = 1; i_result_src = 3; i_branch = 1; i_jmp = 1; i_mem_write = 1;
    i_reg_write = 1; i_alu_ctl = 7; i_alu_src_opb = 1; i_alu_src_opa = 3;
    i_rs1 = 5'h1f; i_rs2 = 5'h1f; i_rd = 5'h1f; i_stall = 1; i_flush = 1;
    #3;
    chk_zero("rst");
    chk("rst.load_use", o_load_use, 0);
    chk("rst.cnt", o_bubble_cnt, 0);
    nop();
    i_valid = 1; i_reg_write = 1; i_alu_ctl = 3'b000; i_rd = 5; i_rs1 = 1; i_rs2 = 2;
    #2 i_rst_n = 1;
    #2 clk_en = 1;
    step();
    chk("add.valid", o_valid, 1);
    chk("add.rd", o_rd, 5);
    chk("add.reg_write", o_reg_write, 1);
    chk("add.cnt", o_bubble_cnt, 0);

    // Load-use stall: rd=7 held, consumer reads rs1=7
    drv_load(7);
    step();
    nop();
    i_valid = 1; i_rs1 = 7; i_rd = 9; i_alu_ctl = 3'b010; i_reg_write = 1;
    #1;
    chk("lu.flag", o_load_use, 1);
    step();
    bump();
    chk_zero("lu.bubble");
    chk("lu.cnt", o_bubble_cnt, exp_cnt);
    chk("lu.flag_after", o_load_use, 0);
    step();
    chk("lu.replay_valid", o_valid, 1);
    chk("lu.replay_rd", o_rd, 9);
    chk("lu.replay_alu", o_alu_ctl, 3'b010);

    // No false hazards
    drv_load(0);
    step();
    nop();
    i_valid = 1; i_rs1 = 0;
    #1;
    chk("nf.rd0", o_load_use, 0);
    drv_load(7);
    step();
    nop();
    i_valid = 0; i_rs2 = 7;
    #1;
    chk("nf.invalid", o_load_use, 0);
    i_mem_write = 1; i_reg_write = 1; i_branch = 1; i_jmp = 1; i_alu_ctl = 5; i_rd = 4;
    step();
    chk("inv.valid", o_valid, 0);
    chk("inv.effects", {o_mem_write, o_reg_write, o_branch, o_jmp}, 0);
    chk("inv.alu", o_alu_ctl, 5);
    chk("inv.rd", o_rd, 4);
    chk("inv.cnt", o_bubble_cnt, exp_cnt);

    // Stall dominates load-use
    drv_load(3);
    step();
    nop();
    i_valid = 1; i_rs2 = 3; i_rd = 8; i_stall = 1;
    #1;
    chk("st.flag0", o_load_use, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("st.valid", o_valid, 1);
      chk("st.rd", o_rd, 3);
      chk("st.src", o_result_src, 2'b01);
      chk("st.flag", o_load_use, 1);
      chk("st.cnt", o_bubble_cnt, exp_cnt);
    end
    i_stall = 0;
    step();
    bump();
    chk_zero("st.bubble");
    chk("st.cnt_after", o_bubble_cnt, exp_cnt);
    step();
    chk("st.replay_rd", o_rd, 8);

    // Flush beats stall; flush plus load-use counts once
    drv_load(6);
    step();
    nop();
    i_valid = 1; i_rs1 = 6; i_mem_write = 1; i_rd = 10; i_flush = 1; i_stall = 1;
    #1;
    chk("fl.flag", o_load_use, 1);
    step();
    bump();
    chk_zero("fl.bubble");
    chk("fl.cnt", o_bubble_cnt, exp_cnt);

    // Async reset during a stall discards the held load
    drv_load(2);
    step();
    nop();
    i_valid = 1; i_rs1 = 2; i_stall = 1;
    step();
    #2 i_rst_n = 0;
    #1;
    exp_cnt = 0;
    chk_zero("rst2");
    chk("rst2.flag", o_load_use, 0);
    chk("rst2.cnt", o_bubble_cnt, 0);
    nop();
    i_valid = 1; i_reg_write = 1; i_rd = 11;
    #1 i_rst_n = 1;
    step();
    chk("rst2.rd", o_rd, 11);
    chk("rst2.valid", o_valid, 1);
    chk("rst2.cnt_after", o_bubble_cnt, 0);

    // Saturation over 20 flushes
    i_flush = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      bump();
      chk("sat.cnt", o_bubble_cnt, exp_cnt);
    end
    chk("sat.valid", o_valid, 0);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("sat.final", o_bubble_cnt, 4'hF);
`else
    chk("sat.final", o_bubble_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
